// File: rtl/stage2_execute_pkg.sv
// Shared RV32I constants, ALU operation encoding and the OP/OP-IMM ALU decoder
// used by the execute stage.
package stage2_execute_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned REGW = 5;

   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [2:0] F3_ADD  = 3'd0;
   localparam logic [2:0] F3_SLL  = 3'd1;
   localparam logic [2:0] F3_SLT  = 3'd2;
   localparam logic [2:0] F3_SLTU = 3'd3;
   localparam logic [2:0] F3_XOR  = 3'd4;
   localparam logic [2:0] F3_SR   = 3'd5;
   localparam logic [2:0] F3_OR   = 3'd6;
   localparam logic [2:0] F3_AND  = 3'd7;

   localparam logic [2:0] F3_BEQ  = 3'd0;
   localparam logic [2:0] F3_BNE  = 3'd1;
   localparam logic [2:0] F3_BLT  = 3'd4;
   localparam logic [2:0] F3_BGE  = 3'd5;
   localparam logic [2:0] F3_BLTU = 3'd6;
   localparam logic [2:0] F3_BGEU = 3'd7;

   localparam logic [2:0] F3_SB   = 3'd0;
   localparam logic [2:0] F3_SH   = 3'd1;
   localparam logic [2:0] F3_SW   = 3'd2;

   // funct7 bit 30 selects SUB and SRA/SRAI
   localparam int unsigned F7_ALT_BIT = 30;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
   } alu_op_e;

   function automatic alu_op_e alu_decode(input logic [XLEN-1:0] instr);
      logic [6:0] opc;
      logic       alt;
      alu_op_e    op;
      opc = instr[6:0];
      alt = instr[F7_ALT_BIT];
      op  = ALU_ADD;
      if (opc == OPC_OP || opc == OPC_OPIMM) begin
         case (instr[14:12])
            F3_ADD:  op = (opc == OPC_OP && alt) ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
         endcase
      end
      return op;
   endfunction

endpackage

// File: rtl/stage2_execute_alu.sv
// Combinational RV32I integer ALU; shift amount is b[4:0].
module stage2_execute_alu
   import stage2_execute_pkg::*;
(
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   input  alu_op_e         alu_op_i,
   output logic [XLEN-1:0] result_o
);

   logic [4:0] shamt;
   assign shamt = b_i[4:0];

   always_comb begin
      result_o = '0;
      case (alu_op_i)
         ALU_ADD:  result_o = a_i + b_i;
         ALU_SUB:  result_o = a_i - b_i;
         ALU_SLL:  result_o = a_i << shamt;
         ALU_SLT:  result_o = {31'd0, $signed(a_i) < $signed(b_i)};
         ALU_SLTU: result_o = {31'd0, a_i < b_i};
         ALU_XOR:  result_o = a_i ^ b_i;
         ALU_SRL:  result_o = a_i >> shamt;
         ALU_SRA:  result_o = $signed(a_i) >>> shamt;
         ALU_OR:   result_o = a_i | b_i;
         ALU_AND:  result_o = a_i & b_i;
         default:  result_o = '0;
      endcase
   end

endmodule

// File: rtl/stage2_execute.sv
// Execute stage of the 3-stage RV32I pipeline: operand forwarding, ALU,
// branch/jump resolution and data-memory request generation.
module stage2_execute
   import stage2_execute_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            hold,
   input  logic [XLEN-1:0] instruction_in,
   input  logic [XLEN-1:0] pc_in,
   input  logic [XLEN-1:0] rs1_data_in,
   input  logic [XLEN-1:0] rs2_data_in,
   input  logic [XLEN-1:0] immediate_in,
   input  logic [XLEN-1:0] wb_data,
   input  logic [REGW-1:0] wb_adr,
   input  logic            wb_enable,
   output logic [XLEN-1:0] instruction_out,
   output logic [XLEN-1:0] alu_out,
   output logic [XLEN-1:0] pc_plus_4,
   output logic [XLEN-1:0] immediate,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   output logic [3:0]      dmem_we,
   output logic            dmem_re,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc
);

   logic [XLEN-1:0] instr_q, instr_d, pc_q, pc_d, rs1_q, rs1_d, rs2_q, rs2_d, imm_q, imm_d;
   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic            fwd1, fwd2, byp1, byp2;
   logic [XLEN-1:0] rs1_fwd, rs2_fwd, alu_a, alu_b, alu_res, jalr_sum;
   logic            br_taken;

   assign opcode = instr_q[6:0];
   assign funct3 = instr_q[14:12];

   // x0 is never forwarded; fwd* act on the held instruction, byp* at capture
   assign fwd1 = wb_enable && (wb_adr != '0) && (wb_adr == instr_q[19:15]);
   assign fwd2 = wb_enable && (wb_adr != '0) && (wb_adr == instr_q[24:20]);
   assign byp1 = wb_enable && (wb_adr != '0) && (wb_adr == instruction_in[19:15]);
   assign byp2 = wb_enable && (wb_adr != '0) && (wb_adr == instruction_in[24:20]);

   assign rs1_fwd = fwd1 ? wb_data : rs1_q;
   assign rs2_fwd = fwd2 ? wb_data : rs2_q;

   assign alu_a = (opcode == OPC_AUIPC) ? pc_q : rs1_fwd;
   assign alu_b = (opcode == OPC_OP) ? rs2_fwd : imm_q;

   stage2_execute_alu u_alu (
      .a_i      (alu_a),
      .b_i      (alu_b),
      .alu_op_i (alu_decode(instr_q)),
      .result_o (alu_res)
   );

   always_comb begin
      br_taken = 1'b0;
      case (funct3)
         F3_BEQ:  br_taken = (rs1_fwd == rs2_fwd);
         F3_BNE:  br_taken = (rs1_fwd != rs2_fwd);
         F3_BLT:  br_taken = ($signed(rs1_fwd) < $signed(rs2_fwd));
         F3_BGE:  br_taken = ($signed(rs1_fwd) >= $signed(rs2_fwd));
         F3_BLTU: br_taken = (rs1_fwd < rs2_fwd);
         F3_BGEU: br_taken = (rs1_fwd >= rs2_fwd);
         default: br_taken = 1'b0;
      endcase
   end

   assign jalr_sum = rs1_fwd + imm_q;

   assign alu_out         = alu_res;
   assign dmem_addr       = alu_res;
   assign pc_plus_4       = pc_q + 32'd4;
   assign immediate       = imm_q;
   assign instruction_out = hold ? NOP_INSTR : instr_q;

   // Requests and redirects only issue in a non-held cycle
   always_comb begin
      redirect_valid = 1'b0;
      redirect_pc    = pc_q + imm_q;
      dmem_re        = 1'b0;
      dmem_we        = 4'b0000;
      dmem_wdata     = rs2_fwd;
      if (opcode == OPC_JALR) begin
         redirect_pc = {jalr_sum[XLEN-1:1], 1'b0};
      end
      if (opcode == OPC_STORE) begin
         case (funct3)
            F3_SB: begin
               dmem_we    = 4'b0001 << alu_res[1:0];
               dmem_wdata = {4{rs2_fwd[7:0]}};
            end
            F3_SH: begin
               dmem_we    = alu_res[0] ? 4'b0000 : (alu_res[1] ? 4'b1100 : 4'b0011);
               dmem_wdata = {2{rs2_fwd[15:0]}};
            end
            F3_SW:   dmem_we = (alu_res[1:0] == 2'b00) ? 4'b1111 : 4'b0000;
            default: dmem_we = 4'b0000;
         endcase
      end
      if (hold) begin
         dmem_we = 4'b0000;
      end else begin
         dmem_re        = (opcode == OPC_LOAD);
         redirect_valid = (opcode == OPC_JAL) || (opcode == OPC_JALR) ||
                          ((opcode == OPC_BRANCH) && br_taken);
      end
   end

   // Next-state: hold refreshes operands from writeback; redirect flushes
   always_comb begin
      instr_d = instr_q;
      pc_d    = pc_q;
      rs1_d   = rs1_q;
      rs2_d   = rs2_q;
      imm_d   = imm_q;
      if (hold) begin
         rs1_d = rs1_fwd;
         rs2_d = rs2_fwd;
      end else begin
         instr_d = redirect_valid ? NOP_INSTR : instruction_in;
         pc_d    = pc_in;
         rs1_d   = byp1 ? wb_data : rs1_data_in;
         rs2_d   = byp2 ? wb_data : rs2_data_in;
         imm_d   = immediate_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         instr_q <= NOP_INSTR;
         pc_q    <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         imm_q   <= '0;
      end else begin
         instr_q <= instr_d;
         pc_q    <= pc_d;
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
         imm_q   <= imm_d;
      end
   end

endmodule

// File: tb/tb_stage2_execute.sv
// Directed self-checking bench for stage2_execute.
module tb_stage2_execute;

   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam logic [31:0] I_ADDI1  = 32'h0050_0093; // addi x1,x0,5
   localparam logic [31:0] I_ADD2   = 32'h0010_8133; // add x2,x1,x1
   localparam logic [31:0] I_ADD3Z  = 32'h0000_01B3; // add x3,x0,x0
   localparam logic [31:0] I_ADDI3  = 32'h0070_0193; // addi x3,x0,7
   localparam logic [31:0] I_ADD4   = 32'h0001_8233; // add x4,x3,x0
   localparam logic [31:0] I_SUB    = 32'h4020_81B3; // sub x3,x1,x2
   localparam logic [31:0] I_SRA    = 32'h4020_D1B3; // sra x3,x1,x2
   localparam logic [31:0] I_SRAI   = 32'h4040_D193; // srai x3,x1,4
   localparam logic [31:0] I_AUIPC  = 32'h1234_5197; // auipc x3,0x12345
   localparam logic [31:0] I_BEQ    = 32'h0000_0463; // beq x0,x0,+8
   localparam logic [31:0] I_BLT    = 32'h0020_C463; // blt x1,x2,+8
   localparam logic [31:0] I_BLTU   = 32'h0020_E463; // bltu x1,x2,+8
   localparam logic [31:0] I_JALR   = 32'h0002_80E7; // jalr x1,0(x5)
   localparam logic [31:0] I_JAL    = 32'h0100_00EF; // jal x1,+16
   localparam logic [31:0] I_SB     = 32'h0020_8023; // sb x2,0(x1)
   localparam logic [31:0] I_SH     = 32'h0020_9023; // sh x2,0(x1)
   localparam logic [31:0] I_SW     = 32'h0020_A023; // sw x2,0(x1)
   localparam logic [31:0] I_LW     = 32'h0040_A183; // lw x3,4(x1)
   localparam logic [31:0] I_ADD5   = 32'h0063_02B3; // add x5,x6,x6

   logic        clk = 1'b0;
   logic        reset, hold, wb_enable, dmem_re, redirect_valid;
   logic [31:0] instruction_in, pc_in, rs1_data_in, rs2_data_in, immediate_in, wb_data;
   logic [4:0]  wb_adr;
   logic [31:0] instruction_out, alu_out, pc_plus_4, immediate, dmem_addr, dmem_wdata, redirect_pc;
   logic [3:0]  dmem_we;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   stage2_execute dut (
      .clk(clk), .reset(reset), .hold(hold),
      .instruction_in(instruction_in), .pc_in(pc_in),
      .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in), .immediate_in(immediate_in),
      .wb_data(wb_data), .wb_adr(wb_adr), .wb_enable(wb_enable),
      .instruction_out(instruction_out), .alu_out(alu_out), .pc_plus_4(pc_plus_4),
      .immediate(immediate), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_we(dmem_we), .dmem_re(dmem_re),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [31:0] imm);
      instruction_in = ins;
      pc_in          = pc;
      rs1_data_in    = r1;
      rs2_data_in    = r2;
      immediate_in   = imm;
   endtask

   task automatic wb(input logic en, input logic [4:0] adr, input logic [31:0] d);
      wb_enable = en;
      wb_adr    = adr;
      wb_data   = d;
   endtask

   task automatic test_reset();
      drive(I_SW, 32'h0, 32'h1000, 32'h1234_5678, 32'h0);
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      #1;
      checks++; if (instruction_out !== NOP) begin failures++; $display("FAIL reset_instr got=%h exp=%h", instruction_out, NOP); end
      checks++; if (dmem_we !== 4'b0000) begin failures++; $display("FAIL reset_we got=%b exp=0000", dmem_we); end
      checks++; if (dmem_re !== 1'b0) begin failures++; $display("FAIL reset_re got=%b exp=0", dmem_re); end
      checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL reset_redirect got=%b exp=0", redirect_valid); end
      checks++; if (pc_plus_4 !== 32'd4) begin failures++; $display("FAIL reset_pc4 got=%h exp=4", pc_plus_4); end
      checks++; if (immediate !== 32'd0) begin failures++; $display("FAIL reset_imm got=%h exp=0", immediate); end
   endtask

   task automatic test_forward();
      drive(I_ADDI1, 32'h0, 32'h0, 32'h0, 32'd5);
      tick();
      checks++; if (alu_out !== 32'd5) begin failures++; $display("FAIL fwd_addi got=%h exp=5", alu_out); end
      drive(I_ADD2, 32'h4, 32'h0, 32'h0, 32'h0);
      tick();
      wb(1'b1, 5'd1, 32'd5);
      #1;
      checks++; if (alu_out !== 32'd10) begin failures++; $display("FAIL fwd_b2b got=%h exp=a", alu_out); end
      checks++; if (instruction_out !== I_ADD2) begin failures++; $display("FAIL fwd_instr got=%h exp=%h", instruction_out, I_ADD2); end
      wb(1'b0, 5'd0, 32'd0);
      drive(I_ADD3Z, 32'h8, 32'h0, 32'h0, 32'h0);
      tick();
      wb(1'b1, 5'd0, 32'd99);
      #1;
      checks++; if (alu_out !== 32'd0) begin failures++; $display("FAIL fwd_x0 got=%h exp=0", alu_out); end
      wb(1'b0, 5'd0, 32'd0);
   endtask

   task automatic test_capture_bypass();
      drive(I_ADDI3, 32'h10, 32'h0, 32'h0, 32'd7);
      tick();
      drive(NOP, 32'h14, 32'h0, 32'h0, 32'h0);
      tick();
      wb(1'b1, 5'd3, 32'd7);
      drive(I_ADD4, 32'h18, 32'h0, 32'h0, 32'h0);
      tick();
      wb(1'b0, 5'd0, 32'd0);
      #1;
      checks++; if (alu_out !== 32'd7) begin failures++; $display("FAIL capture_bypass got=%h exp=7", alu_out); end
   endtask

   task automatic test_alu();
      drive(I_SUB, 32'h20, 32'd5, 32'd7, 32'h0);
      tick();
      checks++; if (alu_out !== 32'hFFFF_FFFE) begin failures++; $display("FAIL alu_sub got=%h exp=fffffffe", alu_out); end
      drive(I_SRA, 32'h24, 32'h8000_0000, 32'h0000_0024, 32'h0);
      tick();
      checks++; if (alu_out !== 32'hF800_0000) begin failures++; $display("FAIL alu_sra got=%h exp=f8000000", alu_out); end
      drive(I_SRAI, 32'h28, 32'h8000_0000, 32'h0, 32'h0000_0404);
      tick();
      checks++; if (alu_out !== 32'hF800_0000) begin failures++; $display("FAIL alu_srai got=%h exp=f8000000", alu_out); end
      drive(I_AUIPC, 32'h400, 32'h0, 32'h0, 32'h1234_5000);
      tick();
      checks++; if (alu_out !== 32'h1234_5400) begin failures++; $display("FAIL alu_auipc got=%h exp=12345400", alu_out); end
      drive(NOP, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0);
      tick();
      checks++; if (pc_plus_4 !== 32'h0) begin failures++; $display("FAIL pc4_wrap got=%h exp=0", pc_plus_4); end
   endtask

   task automatic test_branch();
      drive(I_BEQ, 32'h100, 32'h0, 32'h0, 32'd8);
      tick();
      checks++; if (redirect_valid !== 1'b1) begin failures++; $display("FAIL beq_valid got=%b exp=1", redirect_valid); end
      checks++; if (redirect_pc !== 32'h108) begin failures++; $display("FAIL beq_pc got=%h exp=108", redirect_pc); end
      checks++; if (pc_plus_4 !== 32'h104) begin failures++; $display("FAIL beq_pc4 got=%h exp=104", pc_plus_4); end
      checks++; if (immediate !== 32'd8) begin failures++; $display("FAIL beq_imm got=%h exp=8", immediate); end
      drive(I_ADD2, 32'h104, 32'h0, 32'h0, 32'h0);
      tick();
      checks++; if (instruction_out !== NOP) begin failures++; $display("FAIL flush_instr got=%h exp=%h", instruction_out, NOP); end
      checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL flush_redirect got=%b exp=0", redirect_valid); end
      drive(I_BLT, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'd8);
      tick();
      checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h208) begin failures++; $display("FAIL blt_taken got=%b/%h exp=1/208", redirect_valid, redirect_pc); end
      drive(NOP, 32'h204, 32'h0, 32'h0, 32'h0);
      tick();
      drive(I_BLTU, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'd8);
      tick();
      checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL bltu_not_taken got=%b exp=0", redirect_valid); end
      drive(I_JALR, 32'h304, 32'h203, 32'h0, 32'h0);
      tick();
      checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h202) begin failures++; $display("FAIL jalr got=%b/%h exp=1/202", redirect_valid, redirect_pc); end
      drive(NOP, 32'h308, 32'h0, 32'h0, 32'h0);
      tick();
      drive(I_JAL, 32'h200, 32'h0, 32'h0, 32'd16);
      tick();
      checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h210) begin failures++; $display("FAIL jal got=%b/%h exp=1/210", redirect_valid, redirect_pc); end
      drive(NOP, 32'h204, 32'h0, 32'h0, 32'h0);
      tick();
   endtask

   task automatic test_store();
      drive(I_SB, 32'h40, 32'h1003, 32'h1234_56AB, 32'h0);
      tick();
      checks++; if (dmem_we !== 4'b1000) begin failures++; $display("FAIL sb_we got=%b exp=1000", dmem_we); end
      checks++; if (dmem_wdata !== 32'hABAB_ABAB) begin failures++; $display("FAIL sb_wdata got=%h exp=abababab", dmem_wdata); end
      checks++; if (dmem_addr !== 32'h1003) begin failures++; $display("FAIL sb_addr got=%h exp=1003", dmem_addr); end
      drive(I_SW, 32'h44, 32'h1002, 32'hDEAD_BEEF, 32'h0);
      tick();
      checks++; if (dmem_we !== 4'b0000) begin failures++; $display("FAIL sw_misaligned got=%b exp=0000", dmem_we); end
      drive(I_SH, 32'h48, 32'h1002, 32'h1234_BEEF, 32'h0);
      tick();
      checks++; if (dmem_we !== 4'b1100 || dmem_wdata !== 32'hBEEF_BEEF) begin failures++; $display("FAIL sh got=%b/%h exp=1100/beefbeef", dmem_we, dmem_wdata); end
      drive(I_SW, 32'h4C, 32'h1000, 32'hDEAD_BEEF, 32'h0);
      tick();
      checks++; if (dmem_we !== 4'b1111 || dmem_wdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL sw got=%b/%h exp=1111/deadbeef", dmem_we, dmem_wdata); end
      drive(I_LW, 32'h50, 32'h1000, 32'h0, 32'd4);
      tick();
      checks++; if (dmem_re !== 1'b1 || dmem_addr !== 32'h1004 || dmem_we !== 4'b0000) begin failures++; $display("FAIL lw got=%b/%h/%b exp=1/1004/0000", dmem_re, dmem_addr, dmem_we); end
   endtask

   task automatic test_hold();
      drive(I_ADD5, 32'h60, 32'h0, 32'h0, 32'h0);
      tick();
      hold = 1'b1;
      wb(1'b1, 5'd6, 32'd9);
      drive(I_SW, 32'h64, 32'h1000, 32'h0, 32'h0);
      #1;
      checks++; if (instruction_out !== NOP) begin failures++; $display("FAIL hold_instr got=%h exp=%h", instruction_out, NOP); end
      checks++; if (dmem_we !== 4'b0000 || dmem_re !== 1'b0 || redirect_valid !== 1'b0) begin failures++; $display("FAIL hold_quiet got=%b/%b/%b exp=0000/0/0", dmem_we, dmem_re, redirect_valid); end
      tick();
      wb(1'b0, 5'd0, 32'd0);
      #1;
      checks++; if (instruction_out !== NOP) begin failures++; $display("FAIL hold2_instr got=%h exp=%h", instruction_out, NOP); end
      tick();
      hold = 1'b0;
      #1;
      checks++; if (alu_out !== 32'd18) begin failures++; $display("FAIL hold_release_alu got=%h exp=12", alu_out); end
      checks++; if (instruction_out !== I_ADD5) begin failures++; $display("FAIL hold_release_instr got=%h exp=%h", instruction_out, I_ADD5); end
      drive(I_BEQ, 32'h100, 32'h0, 32'h0, 32'd8);
      tick();
      hold = 1'b1;
      #1;
      checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL hold_branch got=%b exp=0", redirect_valid); end
      tick();
      hold = 1'b0;
      #1;
      checks++; if (redirect_valid !== 1'b1 || instruction_out !== I_BEQ) begin failures++; $display("FAIL hold_branch_release got=%b/%h exp=1/%h", redirect_valid, instruction_out, I_BEQ); end
      drive(NOP, 32'h104, 32'h0, 32'h0, 32'h0);
      tick();
      drive(I_SW, 32'h200, 32'h1000, 32'h5555_AAAA, 32'h0);
      tick();
      hold = 1'b1;
      #1;
      checks++; if (dmem_we !== 4'b0000) begin failures++; $display("FAIL hold_store got=%b exp=0000", dmem_we); end
      hold = 1'b0;
      #1;
      checks++; if (dmem_we !== 4'b1111) begin failures++; $display("FAIL hold_store_release got=%b exp=1111", dmem_we); end
   endtask

   initial begin
      reset = 1'b1;
      hold  = 1'b0;
      wb(1'b0, 5'd0, 32'd0);
      drive(NOP, 32'h0, 32'h0, 32'h0, 32'h0);
      test_reset();
      test_forward();
      test_capture_bypass();
      test_alu();
      test_branch();
      test_store();
      test_hold();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
